serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Bit-serial N-bit adder built around the existing one-bit FADDER cell (ports A, B, Cin, sum, cout).
- Loads two operands plus a carry-in, feeds one bit pair per clock to FADDER, and registers its cout as the next Cin.
- Shifts the FADDER sum into a result register.
- Sits directly upstream of FADDER: it is the sequencer that drives FADDER's inputs and consumes its outputs.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled on rising clk
- a_in  input  WIDTH  operand A, captured when start is accepted
- b_in  input  WIDTH  operand B, captured when start is accepted
- cin_in  input  1  initial carry, captured when start is accepted
- busy  output  1  high while serial addition is in progress
- done  output  1  one-cycle pulse; result valid
- sum_out  output  WIDTH  result, held until next accepted start
- cout_out  output  1  final carry, held with sum_out
- ovf_out  output  1  present only with SERIAL_ADD_OVF_EN

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state=IDLE; busy=0; done=0; sum_out=0; cout_out=0; ovf_out=0.
  - Operand shift registers, carry flop and counter all cleared.
  - A reset mid-RUN aborts the operation with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0 captures a_in, b_in and cin_in (carry flop).
  - Same edge clears sum_out/cout_out/ovf_out and the counter; next state RUN.
- RUN:
  - FADDER A/B are driven by the LSBs of the A/B shift registers; its Cin is driven by the carry flop.
  - On each edge:
    - FADDER sum shifts into the MSB of the result register (right shift).
    - A and B shift right by one.
    - The carry flop takes FADDER cout.
    - The counter increments.
  - Bit i is processed at edge E(i+1).
  - At edge E(WIDTH), i.e. when the counter reaches WIDTH-1 before that edge:
    - The last bit is processed.
    - cout_out takes the final FADDER cout; state becomes DONE.
- DONE:
  - done=1 for exactly one cycle; sum_out/cout_out stable.
  - Next edge: if start=1, behave as the IDLE accept (back-to-back allowed); else go to IDLE.
- busy = (state==RUN). busy is high from after E0 through E(WIDTH), i.e. WIDTH cycles.
- Latency: done is asserted WIDTH edges after the accepting edge.
- start while RUN is ignored: no recapture, no effect on the result.
- sum_out is a register. During RUN it shows partially shifted values; it is valid only when done=1 or afterwards in IDLE.
- Arithmetic: {cout_out,sum_out} = a_in + b_in + cin_in, unsigned, WIDTH+1 bits, no truncation beyond that.

Optional Feature:
- SERIAL_ADD_OVF_EN defined:
  - Adds port ovf_out.
  - At the final RUN edge, ovf_out = (carry into MSB) XOR (final cout), i.e. two's-complement signed overflow.
  - ovf_out is held and cleared like cout_out.
- SERIAL_ADD_OVF_EN undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=8: a=0x35, b=0x4A, cin=0, start at E0 -> busy high 8 cycles; done pulse after E8; sum_out=0x7F, cout_out=0.
- a=0xFF, b=0x01, cin=0 -> sum_out=0x00, cout_out=1. Then a=0xFF, b=0xFF, cin=1 -> sum_out=0xFF, cout_out=1.
- Start 0x10+0x20. Assert start with a=0xAA, b=0x55 at E3 (mid-RUN) -> ignored; result 0x30, cout 0; done still after E8.
- Start 0x12+0x34. Assert rst_n low between E4 and E5 -> busy=0, done=0, sum_out=0x00 immediately; no done pulse. After release, a new start completes normally.
- Back-to-back: start held high in the DONE cycle with a=0x01, b=0x01 -> re-enters RUN; second done exactly 9 cycles after the first, sum_out=0x02.
- SERIAL_ADD_OVF_EN: 0x7F+0x01 -> sum_out=0x80, ovf_out=1. 0x80+0x80 -> sum_out=0x00, cout_out=1, ovf_out=1. 0x05+0x03 -> ovf_out=0.

Source files
------------

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_ctrl (with one-bit cell FADDER)
//  Description : Bit-serial WIDTH-bit adder sequencer. Captures two operands
//                and a carry-in, then feeds one bit pair per clock to the
//                FADDER cell. The cell's cout is registered as the next Cin,
//                and its sum is shifted into the result register.
//                Optional feature macro: SERIAL_ADD_OVF_EN. When it is
//                defined, the ovf_out port is added. ovf_out reports
//                two's-complement signed overflow.
//  Revision    : 1.0 - initial release
// ============================================================================

// One-bit full adder cell driven by the sequencer below.
module FADDER (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic sum,
    output logic cout
);
    assign sum  = A ^ B ^ Cin;
    assign cout = (A & B) | (A & Cin) | (B & Cin);
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf_out
`endif
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    // The counter value seen just before the edge that processes the MSB.
    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             r_ovf;
`endif

    logic w_fa_sum;
    logic w_fa_cout;
    logic w_accept;
    logic w_run;
    logic w_last;

    // The one-bit cell always sees the current LSBs and the carry flop.
    FADDER u_fadder (
        .A    (r_a[0]),
        .B    (r_b[0]),
        .Cin  (r_carry),
        .sum  (w_fa_sum),
        .cout (w_fa_cout)
    );

    // A new operation may start from IDLE or, back-to-back, from DONE.
    // A start request during RUN is ignored.
    assign w_accept = start && ((r_state == c_st_idle) || (r_state == c_st_done));
    assign w_run    = (r_state == c_st_run);
    assign w_last   = w_run && (r_cnt == c_last);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (start) w_state_nxt = c_st_run;
            c_st_run:  if (r_cnt == c_last) w_state_nxt = c_st_done;
            c_st_done: w_state_nxt = start ? c_st_run : c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    // Datapath: capture on accept, then shift one bit per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a     <= a_in;
            r_b     <= b_in;
            r_carry <= cin_in;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else if (w_run) begin
            r_sum   <= {w_fa_sum, r_sum[WIDTH-1:1]};
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_carry <= w_fa_cout;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_cout <= w_fa_cout;
`ifdef SERIAL_ADD_OVF_EN
                // The carry flop holds the carry into the MSB at this edge.
                r_ovf  <= r_carry ^ w_fa_cout;
`endif
            end
        end
    end

    assign busy     = w_run;
    assign done     = (r_state == c_st_done);
    assign sum_out  = r_sum;
    assign cout_out = r_cout;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf_out  = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_add_ctrl
//  Description : Directed self-checking bench for serial_add_ctrl (WIDTH=8).
//                It also checks ovf_out when SERIAL_ADD_OVF_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum_out;
    logic             cout_out;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_out;
`endif

    int n_checks = 0;
    int n_errors = 0;

    serial_add_ctrl #(.WIDTH(WIDTH)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .cin_in   (cin_in),
        .busy     (busy),
        .done     (done),
        .sum_out  (sum_out),
        .cout_out (cout_out)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf_out  (ovf_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present operands with start for exactly one edge (the accepting edge).
    task automatic drive_start(input logic [7:0] a, input logic [7:0] b, input logic c);
        start  = 1'b1;
        a_in   = a;
        b_in   = b;
        cin_in = c;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    // Count edges until done is seen; also count cycles with busy high.
    task automatic wait_done(output int edges, output int busy_cycles);
        edges       = 0;
        busy_cycles = 0;
        while (!done && edges < 20) begin
            if (busy) busy_cycles++;
            @(posedge clk); #1;
            edges++;
        end
    endtask

    // A complete operation with its latency and result checks.
    task automatic do_add(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic c, input logic [7:0] exp_sum, input logic exp_cout);
        int e, bc;
        drive_start(a, b, c);
        wait_done(e, bc);
        check({tag, "_latency"}, e, 8);
        check({tag, "_busy_cycles"}, bc, 8);
        check({tag, "_done"}, done, 1);
        check({tag, "_sum"}, sum_out, exp_sum);
        check({tag, "_cout"}, cout_out, exp_cout);
        @(posedge clk); #1;
        check({tag, "_done_pulse_end"}, done, 0);
        check({tag, "_sum_held"}, sum_out, exp_sum);
    endtask

    initial begin : main
        int e, bc;
        rst_n  = 1'b0;
        start  = 1'b0;
        a_in   = '0;
        b_in   = '0;
        cin_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum_out, 0);
        check("rst_cout", cout_out, 0);
`ifdef SERIAL_ADD_OVF_EN
        check("rst_ovf", ovf_out, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic additions.
        do_add("add_35_4a", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0);
        do_add("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        do_add("add_ff_ff_c1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

        // Start during RUN is ignored.
        drive_start(8'h10, 8'h20, 1'b0);            // accept at E0
        repeat (2) begin @(posedge clk); #1; end    // E1, E2
        start = 1'b1; a_in = 8'hAA; b_in = 8'h55;
        @(posedge clk); #1;                         // E3
        start = 1'b0;
        check("midstart_busy", busy, 1);
        wait_done(e, bc);
        check("midstart_latency", e + 3, 8);
        check("midstart_sum", sum_out, 8'h30);
        check("midstart_cout", cout_out, 0);
        @(posedge clk); #1;

        // Asynchronous reset mid-RUN aborts without a done pulse.
        drive_start(8'h12, 8'h34, 1'b0);            // E0
        repeat (4) begin @(posedge clk); #1; end    // E4
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sum", sum_out, 0);
        e = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done) e++;
        end
        check("abort_no_done", e, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_add("after_abort", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);

        // Back-to-back: start held during the DONE cycle.
        drive_start(8'h35, 8'h4A, 1'b0);
        wait_done(e, bc);
        check("b2b_first_done", done, 1);
        check("b2b_first_sum", sum_out, 8'h7F);
        start = 1'b1; a_in = 8'h01; b_in = 8'h01; cin_in = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_reenter_busy", busy, 1);
        check("b2b_reenter_done", done, 0);
        wait_done(e, bc);
        check("b2b_gap", e + 1, 9);
        check("b2b_sum", sum_out, 8'h02);
        check("b2b_cout", cout_out, 0);
        @(posedge clk); #1;

`ifdef SERIAL_ADD_OVF_EN
        drive_start(8'h7F, 8'h01, 1'b0);
        wait_done(e, bc);
        check("ovf_7f_01_sum", sum_out, 8'h80);
        check("ovf_7f_01_ovf", ovf_out, 1);
        @(posedge clk); #1;
        drive_start(8'h80, 8'h80, 1'b0);
        wait_done(e, bc);
        check("ovf_80_80_sum", sum_out, 8'h00);
        check("ovf_80_80_cout", cout_out, 1);
        check("ovf_80_80_ovf", ovf_out, 1);
        @(posedge clk); #1;
        drive_start(8'h05, 8'h03, 1'b0);
        wait_done(e, bc);
        check("ovf_05_03_sum", sum_out, 8'h08);
        check("ovf_05_03_ovf", ovf_out, 0);
        @(posedge clk); #1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
